// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the write master and the slave side.
package i2c_pkg;

    localparam int unsigned ADDR_BITS = 7;
    localparam logic        RW_WRITE  = 1'b0;

    // Bus phase of the master FSM
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StAddrAck,
        StData,
        StDataAck,
        StStop
    } i2c_state_e;

    // Quarter of the current SCL bit period
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quarter_e;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period prescaler: one-cycle tick every CLK_DIV enabled cycles.
module i2c_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned   CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Count while enabled, hold at zero otherwise so every transaction starts aligned
    always_comb begin
        cnt_d = cnt_q;
        if (!en || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Prescaler register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CntMax);

endmodule

// File: rtl/i2c_master_write.sv
// Single-byte I2C write master: START, address+W, ACK, data, ACK, STOP.
module i2c_master_write
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           data,
    input  logic                 sda_in,
    output logic                 scl_out,
    output logic                 sda_oe,
    output logic                 busy,
    output logic                 done,
    output logic                 ack_err
);

    i2c_state_e state_q, state_d;
    quarter_e   qtr_q, qtr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       ack_err_q, ack_err_d;
    logic       done_q, done_d;
    logic       sda_meta_q, sda_sync_q;
    logic       tick;
    logic       scl_hi;
    logic       in_ack;

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign scl_hi  = (qtr_q == Q2) || (qtr_q == Q3);
    assign in_ack  = (state_q == StAddrAck) || (state_q == StDataAck);

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (busy),
        .tick  (tick)
    );

    // Two-flop synchronizer on the SDA pad; idles high like the pulled-up bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            sda_meta_q <= sda_in;
            sda_sync_q <= sda_meta_q;
        end
    end

    // Next-state: accept, quarter/bit sequencing, ACK sampling
    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;

        if (state_q == StIdle) begin
            // A start in the done cycle is dropped so the bus gets an idle gap
            if (start && !done_q) begin
                shift_d   = {addr, RW_WRITE};
                data_d    = data;
                ack_err_d = 1'b0;
                bit_cnt_d = '0;
                qtr_d     = Q0;
                state_d   = StStart;
            end
        end else if (tick) begin
            qtr_d = quarter_e'(qtr_q + 2'd1);

            // Sample at the end of q2, while SCL is high and SDA is stable
            if (in_ack && (qtr_q == Q2) && sda_sync_q) begin
                ack_err_d = 1'b1;
            end

            if (qtr_q == Q3) begin
                unique case (state_q)
                    StStart: state_d = StAddr;
                    StAddr, StData: begin
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            state_d   = (state_q == StAddr) ? StAddrAck : StDataAck;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            shift_d   = {shift_q[6:0], 1'b0};
                        end
                    end
                    StAddrAck: begin
                        if (ack_err_q) begin
                            state_d = StStop;
                        end else begin
                            shift_d = data_q;
                            state_d = StData;
                        end
                    end
                    StDataAck: state_d = StStop;
                    StStop: begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // Bus drive decoded from phase and quarter; SDA only moves in q0 of a bit
    always_comb begin
        scl_out = 1'b1;
        sda_oe  = 1'b0;
        unique case (state_q)
            StIdle: begin
                scl_out = 1'b1;
                sda_oe  = 1'b0;
            end
            StStart: begin
                scl_out = 1'b1;
                sda_oe  = scl_hi;
            end
            StAddr, StData: begin
                scl_out = scl_hi;
                sda_oe  = ~shift_q[7];
            end
            StAddrAck, StDataAck: begin
                scl_out = scl_hi;
                sda_oe  = 1'b0;
            end
            StStop: begin
                scl_out = scl_hi;
                sda_oe  = (qtr_q != Q3);
            end
            default: begin
                scl_out = 1'b1;
                sda_oe  = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            qtr_q     <= Q0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_i2c_master_write.sv
// Randomized bench for i2c_master_write with a bus-level slave/decoder model.
module tb_i2c_master_write;

    localparam int unsigned CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] addr;
    logic [7:0] data;
    logic       sda_line;
    logic       scl_out;
    logic       sda_oe;
    logic       busy;
    logic       done;
    logic       ack_err;

    // Slave model / bus decoder state
    logic       slave_pull     = 1'b0;
    bit         slave_ack_addr = 1'b1;
    bit         slave_ack_data = 1'b1;
    logic       prev_scl       = 1'b1;
    logic       prev_sda       = 1'b1;
    int         bitpos         = 0;
    int         byte_idx       = 0;
    logic [7:0] cur_byte       = '0;
    logic [7:0] mon_bytes[$];
    logic       mon_acks[$];
    int         start_cnt      = 0;
    int         stop_cnt       = 0;
    int         done_cnt       = 0;
    int         cyc            = 0;

    int n_checks = 0;
    int n_pass   = 0;

    assign sda_line = ~(sda_oe | slave_pull);

    i2c_master_write #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .addr    (addr),
        .data    (data),
        .sda_in  (sda_line),
        .scl_out (scl_out),
        .sda_oe  (sda_oe),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Decode START/STOP/bits from the wires and answer ACK slots like a slave
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (prev_scl && scl_out && (sda_line != prev_sda)) begin
            if (!sda_line) begin
                start_cnt++;
                bitpos     = 0;
                byte_idx   = 0;
                slave_pull = 1'b0;
            end else begin
                stop_cnt++;
            end
        end else if (!prev_scl && scl_out) begin
            if (bitpos < 8) begin
                cur_byte = {cur_byte[6:0], sda_line};
                bitpos++;
                if (bitpos == 8) mon_bytes.push_back(cur_byte);
            end else begin
                mon_acks.push_back(sda_line);
                bitpos = 0;
                byte_idx++;
            end
        end else if (prev_scl && !scl_out) begin
            if (bitpos == 8) slave_pull = (byte_idx == 0) ? slave_ack_addr : slave_ack_data;
            else             slave_pull = 1'b0;
        end
        prev_scl = scl_out;
        prev_sda = sda_line;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One write; the expected bus trace and timing come from the protocol rules
    task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input bit ack_a,
                           input bit ack_d, input bit b2b, input bit junk);
        int t0;
        int done_snap, start_snap, stop_snap;
        bit seen;
        bit busy_drop;
        int exp_lat;
        int exp_nbytes;
        seen      = 1'b0;
        busy_drop = 1'b0;
        slave_ack_addr = ack_a;
        slave_ack_data = ack_d;
        mon_bytes.delete();
        mon_acks.delete();
        done_snap  = done_cnt;
        start_snap = start_cnt;
        stop_snap  = stop_cnt;

        if (!b2b) begin
            repeat (3) @(posedge clk);
            #1;
            check_eq("idle_done", done, 0);
            check_eq("idle_busy", busy, 0);
            @(negedge clk);
            #1;
            addr = a; data = d; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end else begin
            // Called from inside the previous done cycle
            addr = a; data = d; start = 1'b1;
            @(posedge clk);
            #1;
            check_eq("b2b_ignored", busy, 0);
            check_eq("done_width", done, 0);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check_eq("accept_busy", busy, 1);
        t0 = cyc;

        for (int k = 1; k <= 2000 && !seen; k++) begin
            if (junk && (k == 10 || k == 200)) begin
                start = 1'b1; addr = ~a; data = ~d;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
            else if (!busy) busy_drop = 1'b1;
        end
        start = 1'b0;
        addr  = a;
        data  = d;

        exp_lat    = ack_a ? 80 * CLK_DIV : 44 * CLK_DIV;
        exp_nbytes = ack_a ? 2 : 1;
        check_eq("done_seen", seen, 1);
        check_eq("busy_held", busy_drop, 0);
        check_eq("latency", cyc - t0, exp_lat);
        check_eq("busy_at_done", busy, 0);
        check_eq("ack_err", ack_err, (!ack_a || !ack_d) ? 1 : 0);

        @(negedge clk);
        #1;
        check_eq("done_pulses", done_cnt - done_snap, 1);
        check_eq("start_conds", start_cnt - start_snap, 1);
        check_eq("stop_conds", stop_cnt - stop_snap, 1);
        check_eq("nbytes", mon_bytes.size(), exp_nbytes);
        check_eq("nacks", mon_acks.size(), exp_nbytes);
        if (mon_bytes.size() >= 1) check_eq("addr_byte", mon_bytes[0], {a, 1'b0});
        if (mon_acks.size() >= 1)  check_eq("addr_ack", mon_acks[0], ack_a ? 0 : 1);
        if (ack_a && mon_bytes.size() >= 2) check_eq("data_byte", mon_bytes[1], d);
        if (ack_a && mon_acks.size() >= 2)  check_eq("data_ack", mon_acks[1], ack_d ? 0 : 1);
        check_eq("bus_idle", {scl_out, sda_line}, 2'b11);
    endtask

    initial begin
        int snap;
        rst_n = 1'b0;
        start = 1'b0;
        addr  = '0;
        data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_scl", scl_out, 1);
        check_eq("rst_sda_oe", sda_oe, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ack_err", ack_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(7'h24, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        run_txn(7'h24, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        run_txn(7'h24, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        run_txn(7'h24, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1);

        // Reset in q1 of data bit 3 (213 cycles after accept)
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        mon_bytes.delete();
        mon_acks.delete();
        slave_ack_addr = 1'b1;
        slave_ack_data = 1'b1;
        addr = 7'h24; data = 8'h5A; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("rst_txn_busy", busy, 1);
        snap = done_cnt;
        repeat (213) @(posedge clk);
        #1;
        check_eq("pre_rst_scl", scl_out, 0);
        check_eq("pre_rst_bytes", mon_bytes.size(), 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_scl", scl_out, 1);
        check_eq("mid_rst_sda_oe", sda_oe, 0);
        check_eq("mid_rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("mid_rst_no_done", done_cnt - snap, 0);

        run_txn(7'h10, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
        run_txn(7'h33, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
        run_txn(7'h7F, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_txn(7'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
